// File: rtl/gbuff_arbiter.sv
// Round-robin, burst-aware arbiter sharing one single-port global buffer
// between NREQ requesters; grants are registered, buffer controls are muxed combinationally.
module gbuff_arbiter #(
  parameter int NREQ      = 3,
  parameter int IDX_W     = 5,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*IDX_W-1:0]  req_idx,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_wr_en,
  output logic [IDX_W-1:0]       mem_idx,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_data_out,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Handshake: a beat is any cycle with req[i] && gnt[i]; the buffer access
  // happens in that cycle, and a read beat returns rvalid[i] with rdata one
  // cycle later. Requesters hold req for the whole burst and keep their
  // we/idx/wdata stable while req is high.

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] owner_nxt;
  logic [PTR_W-1:0] arb_start;
  logic [PTR_W-1:0] arb_sel;
  logic [NREQ-1:0]  arb_gnt;
  logic             arb_found;
  logic             beat;
  logic             rd_beat;
  logic [0:0]       state;

  assign state   = (|gnt) ? ST_OWN : ST_IDLE;
  assign busy    = |gnt;
  assign rdata   = mem_data_out;
  assign beat    = |(req & gnt);
  assign rd_beat = |(req & gnt & ~req_we);

  always_comb begin
    owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) owner = PTR_W'(i);
    end
  end

  assign owner_nxt = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;

  // After a release the search starts just past the old owner, so a
  // continuously requesting owner is only re-granted when nobody else waits.
  assign arb_start = (state == ST_IDLE) ? ptr : owner_nxt;

  always_comb begin
    int pos;
    pos       = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(arb_start) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!arb_found && req[pos]) begin
        arb_found = 1'b1;
        arb_sel   = PTR_W'(pos);
      end
    end
  end

  always_comb begin
    arb_gnt = '0;
    if (arb_found) arb_gnt[arb_sel] = 1'b1;
  end

  always_comb begin
    mem_wr_en = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] && req[i]) begin
        mem_wr_en = req_we[i];
        mem_idx   = req_idx[i*IDX_W +: IDX_W];
        mem_wdata = req_we[i] ? req_wdata[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      rvalid <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      rvalid <= rd_beat ? gnt : '0;
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            gnt <= arb_gnt;
            cnt <= '0;
          end
        end
        default: begin
          if (beat && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
          end else begin
            // Burst limit reached or owner dropped req: hand over in the same edge.
            ptr <= owner_nxt;
            gnt <= arb_found ? arb_gnt : '0;
            cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule
